// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, controller states,
// ALU operation codes, datapath mux selects and the opcode classifier.
package multicycle_pkg;

    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_SLT  = 6'h2A;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_R     = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam logic [1:0] SRC_A_PC   = 2'd0;
    localparam logic [1:0] SRC_A_REG  = 2'd1;
    localparam logic [1:0] SRC_B_REG  = 2'd0;
    localparam logic [1:0] SRC_B_ONE  = 2'd1;
    localparam logic [1:0] SRC_B_SEXT = 2'd2;
    localparam logic [1:0] SRC_B_ZEXT = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_IMM    = 2'd2;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_MEM, CLS_BNE, CLS_J, CLS_HALT, CLS_ILL
    } op_class_e;

    // All datapath strobes and selects driven in one cycle.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       retire;
    } ctrl_t;

    function automatic op_class_e op_class(input logic [5:0] op);
        op_class = CLS_ILL;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: op_class = CLS_R;
            OP_ADDI, OP_ANDI, OP_ORI:              op_class = CLS_I;
            OP_LW, OP_SW:                          op_class = CLS_MEM;
            OP_BNE:                                op_class = CLS_BNE;
            OP_J:                                  op_class = CLS_J;
            OP_HALT:                               op_class = CLS_HALT;
            default:                               op_class = CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode to ALU operation and immediate-extension select, shared by the
// register-register and immediate execute states.
module alu_op_decode
    import multicycle_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] alu_control,
    output logic       imm_zext
);

    always_comb begin
        alu_control = ALU_ADD;
        imm_zext    = 1'b0;
        case (opcode)
            OP_ADD:  alu_control = ALU_ADD;
            OP_SUB:  alu_control = ALU_SUB;
            OP_AND:  alu_control = ALU_AND;
            OP_OR:   alu_control = ALU_OR;
            OP_SLT:  alu_control = ALU_SLT;
            OP_ADDI: alu_control = ALU_ADD;
            OP_ANDI: begin
                alu_control = ALU_AND;
                imm_zext    = 1'b1;
            end
            OP_ORI: begin
                alu_control = ALU_OR;
                imm_zext    = 1'b1;
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control sequencer: steps each instruction through
// fetch/decode/execute/memory/write-back and drives all datapath strobes.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [5:0] opcode,
    output logic       PC_write,
    output logic       Branch,
    output logic       Reg_write,
    output logic       Mem_to_reg,
    output logic       Reg_dst,
    output logic       IorD,
    output logic       Mem_write,
    output logic       IR_write,
    output logic [1:0] PC_src,
    output logic [1:0] ALU_src_a,
    output logic [1:0] ALU_src_b,
    output logic [3:0] ALU_control,
    output logic       retire,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl, ctrl_o;
    logic [3:0] dec_alu;
    logic       dec_zext;

    alu_op_decode u_alu_op_decode (
        .opcode      (opcode),
        .alu_control (dec_alu),
        .imm_zext    (dec_zext)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        ctrl      = '0;
        case (state_q)
            S_FETCH: begin
                if (Run) begin
                    ctrl.ir_write    = 1'b1;
                    ctrl.pc_write    = 1'b1;
                    ctrl.pc_src      = PC_SRC_ALU;
                    ctrl.alu_src_a   = SRC_A_PC;
                    ctrl.alu_src_b   = SRC_B_ONE;
                    ctrl.alu_control = ALU_ADD;
                    state_d          = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_a   = SRC_A_PC;
                ctrl.alu_src_b   = SRC_B_SEXT;
                ctrl.alu_control = ALU_ADD;
                case (op_class(opcode))
                    CLS_R:    state_d = S_EXEC_R;
                    CLS_I:    state_d = S_EXEC_I;
                    CLS_MEM:  state_d = S_MEM_ADDR;
                    CLS_BNE:  state_d = S_BRANCH;
                    CLS_J:    state_d = S_JUMP;
                    CLS_HALT: state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                ctrl.alu_src_a   = SRC_A_REG;
                ctrl.alu_src_b   = SRC_B_REG;
                ctrl.alu_control = dec_alu;
                state_d          = S_WB_R;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a   = SRC_A_REG;
                ctrl.alu_src_b   = dec_zext ? SRC_B_ZEXT : SRC_B_SEXT;
                ctrl.alu_control = dec_alu;
                state_d          = S_WB_I;
            end
            S_WB_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retire    = 1'b1;
                state_d        = S_FETCH;
            end
            S_WB_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a   = SRC_A_REG;
                ctrl.alu_src_b   = SRC_B_SEXT;
                ctrl.alu_control = ALU_ADD;
                state_d          = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl.iord = 1'b1;
                state_d   = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.retire    = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                // PC load is further qualified by the datapath's ALU zero flag.
                ctrl.alu_src_a   = SRC_A_REG;
                ctrl.alu_src_b   = SRC_B_REG;
                ctrl.alu_control = ALU_SUB;
                ctrl.branch      = 1'b1;
                ctrl.pc_src      = PC_SRC_ALUOUT;
                ctrl.retire      = 1'b1;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_IMM;
                ctrl.retire   = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset blanks every strobe combinationally, not just from the next edge.
    assign ctrl_o      = Reset ? '0 : ctrl;
    assign PC_write    = ctrl_o.pc_write;
    assign Branch      = ctrl_o.branch;
    assign Reg_write   = ctrl_o.reg_write;
    assign Mem_to_reg  = ctrl_o.mem_to_reg;
    assign Reg_dst     = ctrl_o.reg_dst;
    assign IorD        = ctrl_o.iord;
    assign Mem_write   = ctrl_o.mem_write;
    assign IR_write    = ctrl_o.ir_write;
    assign PC_src      = ctrl_o.pc_src;
    assign ALU_src_a   = ctrl_o.alu_src_a;
    assign ALU_src_b   = ctrl_o.alu_src_b;
    assign ALU_control = ctrl_o.alu_control;
    assign retire      = ctrl_o.retire;
    assign halted      = !Reset && (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: an instruction-level model expands each opcode into its
// per-cycle output sequence; a compare process checks every cycle.
module tb_multicycle_control;
    import multicycle_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       PC_write, Branch, Reg_write, Mem_to_reg, Reg_dst, IorD, Mem_write, IR_write;
    logic [1:0] PC_src, ALU_src_a, ALU_src_b;
    logic [3:0] ALU_control, state_dbg;
    logic       retire, halted, illegal;

    always #5 Clock = ~Clock;

    multicycle_control dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .opcode(opcode),
        .PC_write(PC_write), .Branch(Branch), .Reg_write(Reg_write),
        .Mem_to_reg(Mem_to_reg), .Reg_dst(Reg_dst), .IorD(IorD),
        .Mem_write(Mem_write), .IR_write(IR_write), .PC_src(PC_src),
        .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b), .ALU_control(ALU_control),
        .retire(retire), .halted(halted), .illegal(illegal), .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic       pc_write, branch, reg_write, mem_to_reg, reg_dst, iord, mem_write, ir_write;
        logic [1:0] pc_src, src_a, src_b;
        logic [3:0] alu;
        logic       retire, halted, illegal;
        logic [3:0] st;
    } obs_t;

    obs_t       expq[$];
    obs_t       pend[$];
    bit         m_halted = 0, m_ill = 0, pend_halt = 0, pend_ill = 0;
    bit         next_run = 0, do_reset = 0;
    logic [5:0] next_op = 6'h00;
    int         halt_cnt = 0;
    int         n_pass = 0, n_total = 0;
    logic [5:0] legal_ops [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08,
                                   6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h05, 6'h02};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic obs_t blank(input logic [3:0] st);
        obs_t o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t a;
        a = '{PC_write, Branch, Reg_write, Mem_to_reg, Reg_dst, IorD, Mem_write, IR_write,
              PC_src, ALU_src_a, ALU_src_b, ALU_control, retire, halted, illegal, state_dbg};
        return a;
    endfunction

    // Expand one fetched instruction into the cycles that follow FETCH.
    task automatic build(input logic [5:0] op);
        obs_t d, x, w;
        d = blank(4'd1); d.src_b = 2; d.alu = 2;
        pend.push_back(d);
        case (op)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
                x = blank(4'd2); x.src_a = 1; x.src_b = 0;
                x.alu = (op == 6'h20) ? 4'd2 : (op == 6'h22) ? 4'd6 :
                        (op == 6'h24) ? 4'd0 : (op == 6'h25) ? 4'd1 : 4'd7;
                w = blank(4'd4); w.reg_write = 1; w.reg_dst = 1; w.retire = 1;
                pend.push_back(x); pend.push_back(w);
            end
            6'h08, 6'h0C, 6'h0D: begin
                x = blank(4'd3); x.src_a = 1;
                x.src_b = (op == 6'h08) ? 2'd2 : 2'd3;
                x.alu = (op == 6'h08) ? 4'd2 : (op == 6'h0C) ? 4'd0 : 4'd1;
                w = blank(4'd5); w.reg_write = 1; w.retire = 1;
                pend.push_back(x); pend.push_back(w);
            end
            6'h23, 6'h2B: begin
                x = blank(4'd6); x.src_a = 1; x.src_b = 2; x.alu = 2;
                pend.push_back(x);
                if (op == 6'h23) begin
                    w = blank(4'd7); w.iord = 1; pend.push_back(w);
                    w = blank(4'd8); w.reg_write = 1; w.mem_to_reg = 1; w.retire = 1;
                    pend.push_back(w);
                end else begin
                    w = blank(4'd9); w.iord = 1; w.mem_write = 1; w.retire = 1;
                    pend.push_back(w);
                end
            end
            6'h05: begin
                x = blank(4'd10); x.src_a = 1; x.src_b = 0; x.alu = 6;
                x.branch = 1; x.pc_src = 1; x.retire = 1;
                pend.push_back(x);
            end
            6'h02: begin
                x = blank(4'd11); x.pc_write = 1; x.pc_src = 2; x.retire = 1;
                pend.push_back(x);
            end
            default: begin
                pend_halt = 1;
                pend_ill  = (op != 6'h3F);
            end
        endcase
    endtask

    // One clock cycle: drive inputs just after the edge and queue the expected outputs.
    task automatic step();
        obs_t e;
        @(posedge Clock);
        #1;
        if (do_reset) begin
            Reset = 1'b1;
            Run   = 1'b1;
            e     = '0;
            pend.delete();
            m_halted = 0; m_ill = 0; pend_halt = 0; halt_cnt = 0;
        end else begin
            Reset = 1'b0;
            if (pend.size() == 0 && pend_halt) begin
                m_halted = 1; m_ill = pend_ill; pend_halt = 0;
            end
            if (m_halted) begin
                Run = next_run;
                e = blank(4'd12); e.halted = 1; e.illegal = m_ill;
                halt_cnt++;
            end else if (pend.size() != 0) begin
                Run = next_run;
                e = pend.pop_front();
            end else begin
                Run = next_run;
                e = blank(4'd0);
                if (next_run) begin
                    opcode = next_op;
                    e.ir_write = 1; e.pc_write = 1; e.src_b = 1; e.alu = 2;
                    build(next_op);
                end
            end
        end
        expq.push_back(e);
    endtask

    always @(negedge Clock) begin
        obs_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            check("cycle_outputs", 32'(actual()), 32'(e));
        end
    end

    // Run one instruction from FETCH and pin its length and retire count to literals.
    task automatic run_instr(input logic [5:0] op, input int exp_cyc, input int exp_ret);
        int n = 0, r = 0;
        next_run = 1; next_op = op;
        do begin
            step();
            @(negedge Clock);
            n++;
            if (retire) r++;
        end while (pend.size() != 0 && n < 12);
        check($sformatf("cycles_op%02h", op), n, exp_cyc);
        check($sformatf("retires_op%02h", op), r, exp_ret);
    endtask

    function automatic logic [5:0] rand_op();
        int r = $urandom_range(0, 15);
        if (r < 12) return legal_ops[r];
        if (r == 12) return 6'h3F;
        if (r == 13) return 6'($urandom);
        return legal_ops[$urandom_range(0, 11)];
    endfunction

    initial begin
        do_reset = 1; step(); step(); do_reset = 0;
        @(negedge Clock);
        check("reset_state", state_dbg, 0);
        check("reset_illegal", illegal, 0);

        run_instr(6'h20, 4, 1);
        run_instr(6'h23, 5, 1);
        run_instr(6'h2B, 4, 1);
        run_instr(6'h0D, 4, 1);
        run_instr(6'h08, 4, 1);
        run_instr(6'h05, 3, 1);
        run_instr(6'h02, 3, 1);

        next_run = 0;
        repeat (5) step();
        @(negedge Clock);
        check("idle_strobes", {IR_write, PC_write, retire}, 0);
        check("idle_state", state_dbg, 0);

        run_instr(6'h3F, 2, 0);
        repeat (3) step();
        @(negedge Clock);
        check("halt_op_flags", {halted, illegal}, 2'b10);
        do_reset = 1; step(); do_reset = 0;

        run_instr(6'h11, 2, 0);
        repeat (20) step();
        @(negedge Clock);
        check("undef_op_flags", {halted, illegal}, 2'b11);
        check("undef_state", state_dbg, 12);
        do_reset = 1; step(); do_reset = 0;

        next_run = 1; next_op = 6'h23;
        step(); step(); step();
        do_reset = 1; step(); do_reset = 0;
        @(negedge Clock);
        check("rst_mid_strobes", {IR_write, IorD, Reg_write, retire, halted}, 0);
        next_op = 6'h20;
        step();
        @(negedge Clock);
        check("rel_state", state_dbg, 0);
        check("rel_ir_write", IR_write, 1);
        while (pend.size() != 0) step();

        for (int c = 0; c < 3000; c++) begin
            next_run = ($urandom_range(0, 3) != 0);
            next_op  = rand_op();
            do_reset = ($urandom_range(0, 79) == 0) || (m_halted && halt_cnt > 6);
            step();
        end
        do_reset = 0;
        @(negedge Clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
